div_const_pipe: RTL
===================

Name: div_const_pipe

Overview:
- Parametrised, fully pipelined unsigned divider by a compile-time constant DIVISOR. It is the successor to the fixed 32-bit divide-by-3 registered wrapper.
- Processes the dividend MSB-first in CHUNK-bit digits, one digit per pipeline stage, using a per-stage remainder recurrence.
- Adds valid/ready handshake with per-stage bubble collapsing, so it can sit directly in streaming datapaths.
- Used as the standard-architecture reference point for constant-division area/latency comparisons across widths and divisors.

Parameters:
- WIDTH, 32, dividend width in bits. Must be a multiple of CHUNK.
- DIVISOR, 3, constant divisor. Must satisfy 2 <= DIVISOR < 2^WIDTH.
- CHUNK, 4, dividend bits consumed per pipeline stage. Range 1..8.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst_n, input, 1, reset: asynchronous, active-low.
- in_valid, input, 1, dividend on in_x is valid.
- in_ready, output, 1, block accepts in_x this cycle.
- in_x, input, WIDTH, unsigned dividend.
- out_valid, output, 1, out_q is valid.
- out_ready, input, 1, downstream accepts out_q.
- out_q, output, QW, quotient. QW = WIDTH - floor(log2(DIVISOR)), so 31 for WIDTH=32, DIVISOR=3.
- out_r, output, RW, remainder. RW = clog2(DIVISOR). Present only with DIVC_REM_OUT_EN.

Behaviour:
- Pipeline structure:
  - S = WIDTH/CHUNK compute stages, plus one input capture stage, giving S+1 register stages in total.
  - Each stage holds: valid bit, remaining dividend bits, partial quotient (WIDTH bits internally), running remainder (RW bits).
- Input stage:
  - On accept (in_valid & in_ready), latch in_x.
  - Clear the partial quotient and the running remainder.
- Compute stage k (k = 1..S):
  - Take the next CHUNK dividend bits, MSB first, as c.
  - t = r*2^CHUNK + c. New r = t mod DIVISOR.
  - Append digit floor(t/DIVISOR) (CHUNK bits, always < 2^CHUNK) to the partial quotient.
- Output:
  - out_q = the low QW bits of the final partial quotient. Truncation is lossless because the upper bits are provably zero.
  - out_r = the final remainder.
- Latency: exactly S+1 cycles from accept to out_valid when out_ready is held high. WIDTH=32, CHUNK=4 gives 9 cycles.
- Throughput: 1 result per cycle with no backpressure.
- Flow control, per stage:
  - Stage i advances when !valid[i] or stage i+1 advances.
  - The output stage advances when !out_valid or out_ready.
  - in_ready = !valid[0] or stage 0 advances. It is combinational from out_ready through the valid chain; no other combinational input-to-output path exists.
  - Bubbles collapse: an empty stage is filled even while the output is stalled.
- Stall: while out_valid & !out_ready, out_q/out_r and out_valid hold stable.
- Ordering: strict FIFO order; no result is dropped or duplicated.
- Reset:
  - Asynchronous rst_n low clears all valid bits, data registers, out_q and out_r to 0.
  - in_ready is 1 after reset.
  - Reset mid-operation discards all in-flight operands; the first accept after release produces a correct result after S+1 cycles.
- Boundaries:
  - in_x = 0 gives q = 0, r = 0.
  - in_x = 2^WIDTH-1 gives the exact maximal quotient.
  - in_x < DIVISOR gives q = 0, r = in_x.
  - When the pipeline is full and stalled, in_ready = 0.
  - A simultaneous accept and output pop with a full pipeline is permitted and sustains full rate.

Optional Feature:
- DIVC_REM_OUT_EN defined:
  - out_r port exists and carries the remainder, aligned with out_q and out_valid.
- Not defined:
  - out_r port is absent.
  - The last-stage remainder register is not kept; the remainder is still computed internally to drive the recurrence.
  - Quotient behaviour and latency are identical in both builds.

Decomposition:
- Package div_const_pkg:
  - clog2 and quotient-width functions.
  - Derived constants S, QW, RW computed from the parameters.
  - Stage struct typedef {valid, x, q, r}.
  - Parameter legality checks (elaboration-time error on WIDTH % CHUNK != 0 or DIVISOR < 2).
- Sub-module div_const_step:
  - Purely combinational one-chunk recurrence: (r, c) -> (r', digit).
  - Instantiated S times by a generate loop.

Test Plan:
- WIDTH=32, DIVISOR=3, out_ready=1:
  - in_x=0xFFFFFFFF -> q=0x55555555, r=0, exactly 9 cycles after accept.
  - in_x=100 -> q=33, r=1.
- Back-to-back stream 0..999 with out_ready=1 -> 1000 consecutive results, in order, all matching x/3 and x%3, no gaps.
- Backpressure, random out_ready (50%) over 10k random operands:
  - outputs stable while stalled, no loss or duplication.
  - in_ready drops only when all S+1 stages are valid.
- DIVISOR=7, CHUNK=8, WIDTH=16:
  - in_x=0xFFFF -> q=9362, r=1.
  - in_x=6 -> q=0, r=6.
  - latency 3 cycles.
- rst_n pulsed low with 5 operands in flight:
  - all valids clear asynchronously; no stale output appears.
  - next operand 42/3 -> q=14, r=0 after 9 cycles.
- Build without DIVC_REM_OUT_EN:
  - identical quotient stream to the enabled build.
  - out_r absent (elaboration check).

Source files
------------

// File: rtl/div_const_pkg.sv
// div_const_pkg: width helpers and legality check shared by the constant-divider pipeline.
package div_const_pkg;

    function automatic int clog2(input int unsigned v);
        int n = 0;
        longint unsigned p = 64'd1;
        while (p < 64'(v)) begin
            p = p << 1;
            n++;
        end
        return n;
    endfunction

    function automatic int flog2(input int unsigned v);
        int n = 0;
        int unsigned t = v;
        while (t > 32'd1) begin
            t = t >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The quotient of a WIDTH-bit dividend never needs more than WIDTH - floor(log2(DIVISOR)) bits.
    function automatic int quot_width(input int width, input int unsigned divisor);
        return width - flog2(divisor);
    endfunction

    function automatic int rem_width(input int unsigned divisor);
        return clog2(divisor);
    endfunction

    function automatic bit params_legal(input int width, input int unsigned divisor, input int chunk);
        return (chunk >= 1) && (chunk <= 8) && (width % chunk == 0) && (divisor >= 32'd2);
    endfunction

endpackage

// File: rtl/div_const_step.sv
// div_const_step: one CHUNK-bit digit of the division recurrence, (r, c) -> (r', digit), purely combinational.
module div_const_step #(
    parameter int unsigned DIVISOR = 3,
    parameter int          CHUNK   = 4,
    parameter int          RW      = 2
) (
    input  logic [RW-1:0]    r_in,
    input  logic [CHUNK-1:0] c_in,
    output logic [RW-1:0]    r_out,
    output logic [CHUNK-1:0] digit
);
    localparam int            TW    = RW + CHUNK;
    localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

    logic [TW-1:0] t;
    logic [TW-1:0] rem;
    logic [TW-1:0] quo;
    logic          unused_hi;

    // r_in < DIVISOR keeps the digit below 2^CHUNK, so the dropped upper bits are always zero.
    assign t         = {r_in, c_in};
    assign quo       = t / DIV_T;
    assign rem       = t % DIV_T;
    assign r_out     = rem[RW-1:0];
    assign digit     = quo[CHUNK-1:0];
    assign unused_hi = ^{rem[TW-1:RW], quo[TW-1:CHUNK]};

endmodule

// File: rtl/div_const_pipe.sv
// div_const_pipe: fully pipelined unsigned divide by a constant, CHUNK dividend bits per stage, valid/ready.
// Define DIVC_REM_OUT_EN to expose the registered remainder on out_r.
module div_const_pipe
    import div_const_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int unsigned DIVISOR = 3,
    parameter int          CHUNK   = 4,
    localparam int         S       = num_stages(WIDTH, CHUNK),
    localparam int         QW      = quot_width(WIDTH, DIVISOR),
    localparam int         RW      = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DIVC_REM_OUT_EN
    output logic [RW-1:0]    out_r,
`endif
    output logic [QW-1:0]    out_q
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] q;
        logic [RW-1:0]    r;
    } stage_t;

    if (!params_legal(WIDTH, DIVISOR, CHUNK)) begin : g_illegal
        $error("div_const_pipe: WIDTH must be a multiple of CHUNK (1..8) and DIVISOR >= 2");
    end

    stage_t           pipe_q [S];
    stage_t           pipe_d [S];
    logic             out_valid_q, out_valid_d;
    logic [QW-1:0]    out_q_q, out_q_d;
    logic [S:0]       adv;
    logic [RW-1:0]    r_nx [1:S];
    logic [CHUNK-1:0] dig  [1:S];
    logic [WIDTH-1:0] q_full;
    logic             unused_bits;
`ifdef DIVC_REM_OUT_EN
    logic [RW-1:0]    out_r_q, out_r_d;
`endif

    for (genvar k = 1; k <= S; k++) begin : g_step
        div_const_step #(
            .DIVISOR (DIVISOR),
            .CHUNK   (CHUNK),
            .RW      (RW)
        ) u_step (
            .r_in  (pipe_q[k-1].r),
            .c_in  (pipe_q[k-1].x[WIDTH-1 -: CHUNK]),
            .r_out (r_nx[k]),
            .digit (dig[k])
        );
    end

    // A stage may load when it is empty or its contents move on, so bubbles collapse under a stalled output.
    always_comb begin
        adv[S] = !out_valid_q || out_ready;
        for (int i = S - 1; i >= 0; i--) begin
            adv[i] = !pipe_q[i].valid || adv[i+1];
        end
    end

    always_comb begin
        pipe_d      = pipe_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
`ifdef DIVC_REM_OUT_EN
        out_r_d     = out_r_q;
`endif
        q_full      = (pipe_q[S-1].q << CHUNK) | WIDTH'(dig[S]);
        if (adv[0]) begin
            pipe_d[0].valid = in_valid;
            pipe_d[0].x     = in_x;
            pipe_d[0].q     = '0;
            pipe_d[0].r     = '0;
        end
        for (int k = 1; k < S; k++) begin
            if (adv[k]) begin
                pipe_d[k].valid = pipe_q[k-1].valid;
                pipe_d[k].x     = pipe_q[k-1].x << CHUNK;
                pipe_d[k].q     = (pipe_q[k-1].q << CHUNK) | WIDTH'(dig[k]);
                pipe_d[k].r     = r_nx[k];
            end
        end
        if (adv[S]) begin
            out_valid_d = pipe_q[S-1].valid;
            out_q_d     = q_full[QW-1:0];
`ifdef DIVC_REM_OUT_EN
            out_r_d     = r_nx[S];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
`ifdef DIVC_REM_OUT_EN
            out_r_q     <= '0;
`endif
        end else begin
            pipe_q      <= pipe_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
`ifdef DIVC_REM_OUT_EN
            out_r_q     <= out_r_d;
`endif
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
`ifdef DIVC_REM_OUT_EN
    assign out_r       = out_r_q;
    assign unused_bits = ^q_full[WIDTH-1:QW];
`else
    assign unused_bits = ^{q_full[WIDTH-1:QW], r_nx[S]};
`endif

endmodule
